// File: rtl/ifetch_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ifetch_unit_pkg : shared types and constants for the fetch unit |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FETCH = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/ifetch_hold_buf.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ifetch_hold_buf : one-entry {valid, addr, data} stall buffer    |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module ifetch_hold_buf
  import ifetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ifetch_unit : req/ack instruction fetch sequencer feeding IF/ID |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              pcwrite_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              squash_q, squash_nxt;
  logic              buf_load, buf_clear, buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              deliver;
  logic [ADDR_W-1:0] dlv_addr;
  logic [DATA_W-1:0] dlv_data;

  ifetch_hold_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_addr (addr_q),
    .load_data (mem_data_i),
    .valid     (buf_valid),
    .addr      (buf_addr),
    .data      (buf_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      squash_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      squash_q <= squash_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    squash_nxt = squash_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    deliver    = 1'b0;
    dlv_addr   = buf_addr;
    dlv_data   = buf_data;
    mem_req_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) state_nxt = ST_ISSUE;
      end
      // A flush here means pc_i has not yet picked up the branch target.
      ST_ISSUE: begin
        if (flush_i)       state_nxt = ST_ISSUE;
        else if (!start_i) state_nxt = ST_IDLE;
        else               state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          state_nxt = ST_ISSUE;
          if (squash_q || flush_i) begin
            squash_nxt = 1'b0;
          end else if (!stall_i) begin
            deliver  = 1'b1;
            dlv_addr = addr_q;
            dlv_data = mem_data_i;
          end else begin
            buf_load  = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else if (flush_i) begin
          squash_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          buf_clear = 1'b1;
          state_nxt = ST_ISSUE;
        end else if (!stall_i) begin
          deliver   = buf_valid;
          buf_clear = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pcwrite_o  = flush_i | deliver;
  assign mem_addr_o = addr_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q <= '0;
    end else if (state == ST_ISSUE) begin
      addr_q <= pc_i;
    end
  end

  // Flush beats deliver, deliver beats stall; an idle unstalled cycle is a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inst_o       <= NOP_INST;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
    end else if (flush_i) begin
      inst_valid_o <= 1'b0;
    end else if (deliver) begin
      inst_o       <= dlv_data;
      inst_pc_o    <= dlv_addr;
      inst_valid_o <= 1'b1;
    end else if (!stall_i) begin
      inst_valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_ifetch_unit : directed bench with a transaction-level model  |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module tb_ifetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stall_i, flush_i, mem_ack_i;
  logic [31:0] pc_i, mem_data_i;
  logic        pcwrite_o, mem_req_o, inst_valid_o;
  logic [31:0] mem_addr_o, inst_o, inst_pc_o;

  int n_vec = 0;
  int n_err = 0;

  ifetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .pcwrite_o    (pcwrite_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a fetcher that is idle, latching the PC, waiting on memory, or parking a stalled word.
  bit          m_latch, m_out, m_hold, m_squash;
  logic [31:0] m_addr, m_ba, m_bd;
  logic [31:0] e_inst, e_pc;
  bit          e_valid;

  always @(negedge clk_i) begin : model
    bit          dlv;
    logic [31:0] dd, da;
    if (!rst_i) begin
      m_latch = 0; m_out = 0; m_hold = 0; m_squash = 0;
      m_addr = '0; m_ba = '0; m_bd = '0;
      e_inst = 32'h0; e_pc = '0; e_valid = 0;
      check("rst_req",   32'(mem_req_o),    32'd0);
      check("rst_addr",  mem_addr_o,        32'd0);
      check("rst_inst",  inst_o,            32'd0);
      check("rst_pc",    inst_pc_o,         32'd0);
      check("rst_valid", 32'(inst_valid_o), 32'd0);
    end else begin
      dlv = 0; dd = '0; da = '0;
      if (m_out && mem_ack_i && !flush_i && !m_squash && !stall_i) begin
        dlv = 1; dd = mem_data_i; da = m_addr;
      end
      if (m_hold && !flush_i && !stall_i) begin
        dlv = 1; dd = m_bd; da = m_ba;
      end
      check("req", 32'(mem_req_o), 32'(m_out));
      if (m_out) check("addr", mem_addr_o, m_addr);
      check("pcwrite", 32'(pcwrite_o), 32'(flush_i | dlv));
      check("inst",    inst_o,            e_inst);
      check("inst_pc", inst_pc_o,         e_pc);
      check("valid",   32'(inst_valid_o), 32'(e_valid));

      if (flush_i)       e_valid = 0;
      else if (dlv)      begin e_inst = dd; e_pc = da; e_valid = 1; end
      else if (!stall_i) e_valid = 0;

      if (m_latch) begin
        m_addr = pc_i;
        if (!flush_i) begin
          m_latch = 0;
          m_out   = start_i;
        end
      end else if (m_out) begin
        if (mem_ack_i) begin
          m_out   = 0;
          m_latch = 1;
          if (m_squash || flush_i) m_squash = 0;
          else if (stall_i) begin
            m_hold = 1; m_latch = 0; m_ba = m_addr; m_bd = mem_data_i;
          end
        end else if (flush_i) begin
          m_squash = 1;
        end
      end else if (m_hold) begin
        if (flush_i || !stall_i) begin
          m_hold = 0; m_latch = 1;
        end
      end else if (start_i) begin
        m_latch = 1;
      end
    end
  end

  // Drive one cycle of inputs just after the edge; return mid-cycle for literal checks.
  task automatic step(input logic st, input logic [31:0] pc, input logic stl,
                      input logic fl, input logic ak, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    start_i = st; pc_i = pc; stall_i = stl; flush_i = fl; mem_ack_i = ak; mem_data_i = d;
    #2;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (2) @(posedge clk_i);
    #3;
    check("t0_req",   32'(mem_req_o),    32'd0);
    check("t0_valid", 32'(inst_valid_o), 32'd0);
    check("t0_inst",  inst_o,            32'h0000_0000);
    @(posedge clk_i); #1; rst_i = 1'b1;

    // Basic fetch, three memory cycles
    step(1, 32'h0, 0, 0, 0, 32'h0);
    step(1, 32'h0, 0, 0, 0, 32'h0);
    step(1, 32'h0, 0, 0, 0, 32'h0);
    check("t1_req", 32'(mem_req_o), 32'd1);
    check("t1_addr", mem_addr_o, 32'h0);
    check("t1_pcw_wait", 32'(pcwrite_o), 32'd0);
    step(1, 32'h0, 0, 0, 0, 32'h0);
    step(1, 32'h0, 0, 0, 1, 32'h1111_1111);
    check("t1_pcw_ack", 32'(pcwrite_o), 32'd1);
    step(1, 32'h4, 0, 0, 0, 32'h0);
    check("t1_inst", inst_o, 32'h1111_1111);
    check("t1_pc", inst_pc_o, 32'h0);
    check("t1_valid", 32'(inst_valid_o), 32'd1);
    check("t1_pcw_after", 32'(pcwrite_o), 32'd0);

    // Stall in the ack cycle, released four cycles later
    step(1, 32'h4, 0, 0, 0, 32'h0);
    step(1, 32'h4, 1, 0, 1, 32'hAAAA_0001);
    check("t2_pcw_ack", 32'(pcwrite_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h4, 1, 0, 0, 32'h0);
      check("t2_pcw_stall", 32'(pcwrite_o), 32'd0);
      check("t2_inst_hold", inst_o, 32'h1111_1111);
    end
    step(1, 32'h4, 0, 0, 0, 32'h0);
    check("t2_pcw_rel", 32'(pcwrite_o), 32'd1);
    step(1, 32'h8, 0, 0, 0, 32'h0);
    check("t2_inst", inst_o, 32'hAAAA_0001);
    check("t2_pc", inst_pc_o, 32'h4);
    check("t2_valid", 32'(inst_valid_o), 32'd1);

    // Flush one cycle before the ack of pc=0x8
    step(1, 32'h8, 0, 0, 0, 32'h0);
    check("t3_addr", mem_addr_o, 32'h8);
    step(1, 32'h8, 0, 1, 0, 32'h0);
    check("t3_pcw_flush", 32'(pcwrite_o), 32'd1);
    step(1, 32'h40, 0, 0, 1, 32'hDEAD_BEEF);
    check("t3_pcw_squash", 32'(pcwrite_o), 32'd0);
    check("t3_valid", 32'(inst_valid_o), 32'd0);
    step(1, 32'h40, 0, 0, 0, 32'h0);

    // Flush coincident with ack
    step(1, 32'h40, 0, 1, 1, 32'h0BAD_BAD0);
    check("t4_addr", mem_addr_o, 32'h40);
    check("t4_pcw", 32'(pcwrite_o), 32'd1);
    step(1, 32'h80, 0, 0, 0, 32'h0);
    check("t4_valid", 32'(inst_valid_o), 32'd0);
    step(1, 32'h80, 0, 0, 1, 32'h2222_2222);
    check("t4_addr2", mem_addr_o, 32'h80);
    check("t4_pcw2", 32'(pcwrite_o), 32'd1);
    step(1, 32'h84, 0, 0, 0, 32'h0);
    check("t4_inst", inst_o, 32'h2222_2222);
    check("t4_pc", inst_pc_o, 32'h80);

    // start_i dropped mid-fetch
    step(0, 32'h84, 0, 0, 0, 32'h0);
    check("t6_req", 32'(mem_req_o), 32'd1);
    step(0, 32'h84, 0, 0, 1, 32'h3333_3333);
    check("t6_pcw", 32'(pcwrite_o), 32'd1);
    step(0, 32'h88, 0, 0, 0, 32'h0);
    check("t6_inst", inst_o, 32'h3333_3333);
    check("t6_pc", inst_pc_o, 32'h84);
    step(0, 32'h88, 0, 0, 0, 32'h0);
    check("t6_idle_req", 32'(mem_req_o), 32'd0);
    step(0, 32'h88, 0, 0, 0, 32'h0);
    check("t6_idle_req2", 32'(mem_req_o), 32'd0);

    // Reset in the middle of a fetch
    step(1, 32'h100, 0, 0, 0, 32'h0);
    step(1, 32'h100, 0, 0, 0, 32'h0);
    step(1, 32'h100, 0, 0, 0, 32'h0);
    check("t5_req_pre", 32'(mem_req_o), 32'd1);
    @(posedge clk_i); #1; rst_i = 1'b0; #1;
    check("t5_req", 32'(mem_req_o), 32'd0);
    check("t5_inst", inst_o, 32'h0000_0000);
    check("t5_pc", inst_pc_o, 32'h0);
    check("t5_valid", 32'(inst_valid_o), 32'd0);
    check("t5_addr", mem_addr_o, 32'h0);
    @(posedge clk_i);
    @(posedge clk_i); #1; rst_i = 1'b1;

    // Single-cycle memory: one instruction every two cycles, then stall + flush in HOLD
    step(1, 32'h200, 0, 0, 0, 32'h0);
    step(1, 32'h200, 0, 0, 1, 32'h4444_4444);
    check("t7_addr", mem_addr_o, 32'h200);
    check("t7_pcw", 32'(pcwrite_o), 32'd1);
    step(1, 32'h204, 0, 0, 0, 32'h0);
    check("t7_inst", inst_o, 32'h4444_4444);
    check("t7_pc", inst_pc_o, 32'h200);
    step(1, 32'h204, 0, 0, 1, 32'h5555_5555);
    check("t7_pcw2", 32'(pcwrite_o), 32'd1);
    step(1, 32'h208, 0, 0, 0, 32'h0);
    check("t7_inst2", inst_o, 32'h5555_5555);
    check("t7_valid2", 32'(inst_valid_o), 32'd1);
    step(1, 32'h208, 1, 0, 1, 32'h6666_6666);
    check("t8_pcw_stall", 32'(pcwrite_o), 32'd0);
    step(1, 32'h208, 1, 1, 0, 32'h0);
    check("t8_pcw_flush", 32'(pcwrite_o), 32'd1);
    step(1, 32'h300, 0, 0, 0, 32'h0);
    check("t8_valid", 32'(inst_valid_o), 32'd0);
    check("t8_inst", inst_o, 32'h5555_5555);
    step(1, 32'h300, 0, 0, 0, 32'h0);
    check("t8_addr", mem_addr_o, 32'h300);
    step(0, 32'h300, 0, 0, 1, 32'h7777_7777);

    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
